// File: rtl/fe_frame_scheduler.sv
// fe_frame_scheduler: round-robin owner of the shared feature extractor.
// Grants one frame source at a time, forwards its pixels, tags results.
module fe_frame_scheduler #(
  parameter int IMG_WIDTH      = 32,
  parameter int IMG_HEIGHT     = 32,
  parameter int RESULT_COUNT   = ((IMG_WIDTH-2)/2)*((IMG_WIDTH-2)/2),
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [1:0]  src_valid,
  input  logic [15:0] src_pixel,
  output logic [1:0]  src_ready,
  output logic        fe_start,
  output logic        fe_pixel_valid,
  output logic [7:0]  fe_pixel,
  input  logic [21:0] fe_result,
  input  logic        fe_result_valid,
  input  logic        fe_done,
  output logic [21:0] res_data,
  output logic        res_valid,
  output logic        res_id,
  output logic [7:0]  res_index,
  output logic        frame_done,
  output logic        frame_id,
  output logic        frame_error,
  output logic        busy
);

  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int PW   = $clog2(NPIX);
  localparam int RW   = $clog2(RESULT_COUNT + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [RW-1:0] res_cnt_q, res_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q, err_d;
  logic          res_valid_q, res_valid_d;
  logic [21:0]   res_data_q, res_data_d;
  logic          res_id_q, res_id_d;
  logic [7:0]    res_idx_q, res_idx_d;

  logic       gsel;
  logic [1:0] win;
  logic       pix_acc;
  logic       last_pix;
  logic       tmo_hit;
  logic       res_full;
  logic       fwd;

  assign gsel     = gnt_q[1];
  assign last_pix = pix_cnt_q == PW'(NPIX - 1);
  assign tmo_hit  = tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1);
  assign res_full = res_cnt_q == RW'(RESULT_COUNT);
  assign pix_acc  = (state_q == S_STREAM) && |(src_valid & gnt_q);

  // On a tie the source that was not served last wins.
  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = last_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      last_q      <= 1'b1;
      pix_cnt_q   <= '0;
      res_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
      res_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      pix_cnt_q   <= pix_cnt_d;
      res_cnt_q   <= res_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_idx_q   <= res_idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) state_d = S_START;
      end
      S_START: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (pix_acc && last_pix) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (fe_done || tmo_hit) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    gnt_d       = gnt_q;
    last_d      = last_q;
    pix_cnt_d   = pix_cnt_q;
    res_cnt_d   = res_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    err_d       = err_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_idx_d   = res_idx_q;
    fwd         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|req) gnt_d = win;
      end
      S_START: begin
        pix_cnt_d = '0;
        res_cnt_d = '0;
        tmo_cnt_d = '0;
        err_d     = 1'b0;
      end
      S_STREAM: begin
        fwd = fe_result_valid;
        if (pix_acc) pix_cnt_d = pix_cnt_q + 1'b1;
        // Early done still lets the frame finish, but it is reported.
        if (fe_done) err_d = 1'b1;
      end
      S_DRAIN: begin
        fwd       = fe_result_valid;
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (tmo_hit && !fe_done) err_d = 1'b1;
      end
      S_DONE: begin
        fwd    = fe_result_valid;
        gnt_d  = '0;
        last_d = gsel;
      end
      default: begin
        gnt_d = '0;
      end
    endcase
    if (fwd) begin
      if (res_full) begin
        err_d = 1'b1;
      end else begin
        res_valid_d = 1'b1;
        res_data_d  = fe_result;
        res_id_d    = gsel;
        res_idx_d   = 8'(res_cnt_q);
        res_cnt_d   = res_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    busy           = state_q != S_IDLE;
    gnt            = gnt_q;
    fe_start       = state_q == S_START;
    src_ready      = (state_q == S_STREAM) ? gnt_q : 2'b00;
    fe_pixel_valid = pix_acc;
    fe_pixel       = '0;
    if (pix_acc) begin
      fe_pixel = gsel ? src_pixel[15:8] : src_pixel[7:0];
    end
    frame_done     = state_q == S_DONE;
    frame_id       = frame_done && gsel;
    frame_error    = frame_done && (err_q || !res_full);
    res_valid      = res_valid_q;
    res_data       = res_data_q;
    res_id         = res_id_q;
    res_index      = res_idx_q;
  end

endmodule

// File: tb/tb_fe_frame_scheduler.sv
// Bench for fe_frame_scheduler: two frame sources, a behavioural
// extractor and a golden conv/ReLU/pool reference.
module tb_fe_frame_scheduler;

  localparam int NPIX = 1024;
  localparam int NRES = 225;
  localparam int TMO  = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  gnt;
  logic [1:0]  src_valid = '0;
  logic [15:0] src_pixel = '0;
  logic [1:0]  src_ready;
  logic        fe_start;
  logic        fe_pixel_valid;
  logic [7:0]  fe_pixel;
  logic [21:0] fe_result = '0;
  logic        fe_result_valid = 1'b0;
  logic        fe_done = 1'b0;
  logic [21:0] res_data;
  logic        res_valid;
  logic        res_id;
  logic [7:0]  res_index;
  logic        frame_done;
  logic        frame_id;
  logic        frame_error;
  logic        busy;

  fe_frame_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .src_valid(src_valid), .src_pixel(src_pixel),
    .src_ready(src_ready), .fe_start(fe_start),
    .fe_pixel_valid(fe_pixel_valid), .fe_pixel(fe_pixel),
    .fe_result(fe_result), .fe_result_valid(fe_result_valid),
    .fe_done(fe_done), .res_data(res_data),
    .res_valid(res_valid), .res_id(res_id),
    .res_index(res_index), .frame_done(frame_done),
    .frame_id(frame_id), .frame_error(frame_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int idx;
    int data;
    int cyc;
  } res_t;

  typedef struct {
    int id;
    int err;
    int cyc;
  } done_t;

  res_t  res_q[$];
  done_t done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gidx = 0;
  int src_pos[2] = '{NPIX, NPIX};
  int acc[2] = '{0, 0};
  int ext_img[NPIX];
  int ref_img[NPIX];
  int gold[2][NRES];
  int ext_pix = 0;
  int ext_emit = 0;
  int ext_act = 0;
  // 0 normal, 1 never done, 2 ten results, 3 one extra result
  int mode = 0;
  int gaps = 0;
  int badv = 0;
  int ovl = 0;
  int start_cnt = 0;
  int drain_cyc = 0;

  function automatic int pix(int s, int i);
    int x, y;
    x = i % 32;
    y = i / 32;
    if (s == 0) return 100 + (x ^ y);
    return (x * 7 + y * 13 + 5) % 256;
  endfunction

  function automatic int kw(int t);
    case (t)
      0: return 1;
      1: return -2;
      2: return 1;
      3: return 2;
      4: return -1;
      5: return 0;
      6: return -1;
      7: return 3;
      default: return 1;
    endcase
  endfunction

  // 3x3 conv, ReLU, then max of each 2x2 block of the 30x30 map.
  function automatic int feat(input int img[NPIX], input int k);
    int r, c, best, a;
    r = k / 15;
    c = k % 15;
    best = 0;
    for (int dy = 0; dy < 2; dy++) begin
      for (int dx = 0; dx < 2; dx++) begin
        a = 0;
        for (int t = 0; t < 9; t++) begin
          a += kw(t) * img[(2*r+dy+t/3)*32 + 2*c+dx+t%3];
        end
        if (a > best) best = a;
      end
    end
    return best;
  endfunction

  function automatic int need(int k);
    int n;
    n = (2 * (k / 15) + 4) * 32;
    return (n > NPIX) ? NPIX : n;
  endfunction

  task automatic drive();
    int lim;
    for (int i = 0; i < 2; i++) begin
      if (src_pos[i] < NPIX &&
          (gaps == 0 || $urandom_range(0, 99) >= 30)) begin
        src_valid[i] = 1'b1;
        src_pixel[8*i +: 8] = 8'(pix(i, src_pos[i]));
      end else begin
        src_valid[i] = 1'b0;
        src_pixel[8*i +: 8] = 8'($urandom);
      end
    end
    fe_result_valid = 1'b0;
    fe_done = 1'b0;
    fe_result = 22'($urandom);
    lim = (mode == 2) ? 10 : (mode == 3) ? NRES + 1 : NRES;
    if (ext_act != 0) begin
      if (ext_emit < lim && ext_pix >= need(ext_emit) &&
          $urandom_range(0, 2) != 0) begin
        fe_result_valid = 1'b1;
        fe_result = (ext_emit < NRES) ?
                    22'(feat(ext_img, ext_emit)) : 22'(12345);
        ext_emit++;
        if ((mode == 0 || mode == 3) && ext_emit == lim) begin
          fe_done = 1'b1;
          ext_act = 0;
        end
      end else if (mode == 2 && ext_emit == lim &&
                   ext_pix == NPIX) begin
        fe_done = 1'b1;
        ext_act = 0;
      end
    end
  endtask

  task automatic sample();
    res_t  r;
    done_t d;
    cyc++;
    if (rst) begin
      ext_act = 0;
      src_pos = '{NPIX, NPIX};
    end else begin
      if (fe_start) begin
        start_cnt++;
        gidx = gnt[1] ? 1 : 0;
        ext_pix = 0;
        ext_emit = 0;
        ext_act = 1;
        src_pos[gidx] = 0;
      end
      if (fe_pixel_valid) begin
        if (gnt == 2'b00 || !src_valid[gidx] ||
            fe_pixel !== src_pixel[8*gidx +: 8]) badv++;
        if (ext_pix < NPIX) ext_img[ext_pix] = int'(fe_pixel);
        ext_pix++;
      end
      for (int i = 0; i < 2; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          src_pos[i]++;
          acc[i]++;
          if (src_pos[i] == NPIX) drain_cyc = cyc + 1;
        end
      end
      if (gnt == 2'b11) ovl++;
      if (res_valid) begin
        r.id = int'(res_id);
        r.idx = int'(res_index);
        r.data = int'($signed(res_data));
        r.cyc = cyc;
        res_q.push_back(r);
      end
      if (frame_done) begin
        d.id = int'(frame_id);
        d.err = int'(frame_error);
        d.cyc = cyc;
        done_q.push_back(d);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    cycle();
    cycle();
    rst = 1'b0;
    res_q.delete();
    done_q.delete();
    acc = '{0, 0};
    badv = 0;
    ovl = 0;
    start_cnt = 0;
    ext_pix = 0;
  endtask

  // Requests p0/p1 frames; each source holds req until granted.
  task automatic run_frames(input int p0, input int p1,
                            input int budget, output bit ok);
    int pend[2];
    int target;
    pend[0] = p0;
    pend[1] = p1;
    target = done_q.size() + p0 + p1;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      req = {1'(pend[1] > 0), 1'(pend[0] > 0)};
      cycle();
      if (fe_start) pend[gidx]--;
      if (done_q.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
    req = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    checks++;
    if (gnt !== 2'b00) begin
      errors++; $display("FAIL reset_gnt got %b want 00", gnt);
    end
    checks++;
    if (busy !== 1'b0 || fe_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b%b want 00", busy, fe_start);
    end
    checks++;
    if (src_ready !== 2'b00 || fe_pixel_valid !== 1'b0 ||
        fe_pixel !== 8'd0) begin
      errors++;
      $display("FAIL reset_pix got %b %b %h want 00 0 00",
               src_ready, fe_pixel_valid, fe_pixel);
    end
    checks++;
    if ({res_valid, res_id, res_index, res_data} !== '0) begin
      errors++;
      $display("FAIL reset_res got %b %b %h %h want zeros",
               res_valid, res_id, res_index, res_data);
    end
    checks++;
    if ({frame_done, frame_id, frame_error} !== 3'b000) begin
      errors++;
      $display("FAIL reset_frame got %b%b%b want 000",
               frame_done, frame_id, frame_error);
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (busy !== 1'b0 || gnt !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_req got busy=%b gnt=%b want 0 00",
               busy, gnt);
    end
  endtask

  task automatic test_src0_xor();
    bit seen;
    do_reset();
    mode = 0;
    gaps = 0;
    req = 2'b01;
    cycle();
    checks++;
    if (gnt !== 2'b01 || fe_start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL grant_latency got gnt=%b start=%b busy=%b want 01 1 1",
               gnt, fe_start, busy);
    end
    req = '0;
    seen = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      cycle();
      if (done_q.size() > 0) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL src0_done got none want frame_done");
    end
    checks++;
    if (acc[0] !== NPIX || ext_pix !== NPIX || badv !== 0) begin
      errors++;
      $display("FAIL src0_pixels got acc=%0d fwd=%0d bad=%0d want 1024 1024 0",
               acc[0], ext_pix, badv);
    end
    checks++;
    if (res_q.size() !== NRES) begin
      errors++;
      $display("FAIL src0_count got %0d want %0d", res_q.size(), NRES);
    end
    for (int k = 0; k < res_q.size() && k < NRES; k++) begin
      checks++;
      if (res_q[k].id !== 0 || res_q[k].idx !== k ||
          res_q[k].data !== gold[0][k]) begin
        errors++;
        $display("FAIL src0_res[%0d] got id=%0d idx=%0d d=%0d want 0 %0d %0d",
                 k, res_q[k].id, res_q[k].idx, res_q[k].data, k, gold[0][k]);
      end
    end
    if (seen) begin
      checks++;
      if (done_q[0].id !== 0 || done_q[0].err !== 0 || start_cnt !== 1) begin
        errors++;
        $display("FAIL src0_frame got id=%0d err=%0d starts=%0d want 0 0 1",
                 done_q[0].id, done_q[0].err, start_cnt);
      end
      checks++;
      if (res_q.size() == 0 || res_q[res_q.size()-1].cyc !== done_q[0].cyc) begin
        errors++;
        $display("FAIL last_res_with_done got res_valid not aligned want same cycle as frame_done (cyc %0d)",
                 done_q[0].cyc);
      end
    end
    cycle();
    checks++;
    if (busy !== 1'b0 || gnt !== 2'b00) begin
      errors++;
      $display("FAIL src0_idle got busy=%b gnt=%b want 0 00", busy, gnt);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int j;
    do_reset();
    run_frames(1, 1, 5000, ok);
    checks++;
    if (!ok || done_q.size() !== 2) begin
      errors++;
      $display("FAIL rr_frames got ok=%0d done=%0d want 1 2", ok, done_q.size());
    end else begin
      checks++;
      if (done_q[0].id !== 0 || done_q[1].id !== 1 ||
          done_q[0].err !== 0 || done_q[1].err !== 0) begin
        errors++;
        $display("FAIL rr_order got %0d/%0d err %0d/%0d want 0/1 err 0/0",
                 done_q[0].id, done_q[1].id, done_q[0].err, done_q[1].err);
      end
    end
    checks++;
    if (ovl !== 0 || res_q.size() !== 2 * NRES) begin
      errors++;
      $display("FAIL rr_overlap got ovl=%0d res=%0d want 0 450", ovl, res_q.size());
    end
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < NRES; k++) begin
        j = f * NRES + k;
        if (j >= res_q.size()) break;
        checks++;
        if (res_q[j].id !== f || res_q[j].idx !== k ||
            res_q[j].data !== gold[f][k]) begin
          errors++;
          $display("FAIL rr_res[%0d] got id=%0d idx=%0d d=%0d want %0d %0d %0d",
                   j, res_q[j].id, res_q[j].idx, res_q[j].data, f, k, gold[f][k]);
        end
      end
    end
  endtask

  task automatic test_alternate();
    bit ok;
    do_reset();
    run_frames(2, 1, 7000, ok);
    checks++;
    if (!ok || done_q.size() !== 3) begin
      errors++;
      $display("FAIL alt_frames got ok=%0d done=%0d want 1 3", ok, done_q.size());
    end else begin
      checks++;
      if (done_q[0].id !== 0 || done_q[1].id !== 1 || done_q[2].id !== 0) begin
        errors++;
        $display("FAIL alt_order got %0d,%0d,%0d want 0,1,0",
                 done_q[0].id, done_q[1].id, done_q[2].id);
      end
      checks++;
      if (done_q[0].err + done_q[1].err + done_q[2].err !== 0 ||
          res_q.size() !== 3 * NRES || ovl !== 0) begin
        errors++;
        $display("FAIL alt_clean got res=%0d ovl=%0d want 675 0",
                 res_q.size(), ovl);
      end
    end
  endtask

  task automatic test_gaps();
    bit ok;
    do_reset();
    gaps = 1;
    run_frames(1, 0, 4000, ok);
    gaps = 0;
    checks++;
    if (!ok || done_q.size() == 0 || done_q[0].err !== 0) begin
      errors++;
      $display("FAIL gaps_frame got ok=%0d done=%0d want clean frame",
               ok, done_q.size());
    end
    checks++;
    if (acc[0] !== NPIX || ext_pix !== NPIX || badv !== 0) begin
      errors++;
      $display("FAIL gaps_pixels got acc=%0d fwd=%0d bad=%0d want 1024 1024 0",
               acc[0], ext_pix, badv);
    end
    checks++;
    if (res_q.size() !== NRES) begin
      errors++;
      $display("FAIL gaps_count got %0d want %0d", res_q.size(), NRES);
    end
    for (int k = 0; k < res_q.size() && k < NRES; k++) begin
      checks++;
      if (res_q[k].idx !== k || res_q[k].data !== gold[0][k]) begin
        errors++;
        $display("FAIL gaps_res[%0d] got idx=%0d d=%0d want %0d %0d",
                 k, res_q[k].idx, res_q[k].data, k, gold[0][k]);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    mode = 1;
    run_frames(1, 0, 6000, ok);
    mode = 0;
    checks++;
    if (!ok || done_q.size() !== 1) begin
      errors++;
      $display("FAIL tmo_frame got ok=%0d done=%0d want 1 1", ok, done_q.size());
    end else begin
      checks++;
      if (done_q[0].err !== 1 || done_q[0].id !== 0) begin
        errors++;
        $display("FAIL tmo_error got err=%0d id=%0d want 1 0",
                 done_q[0].err, done_q[0].id);
      end
      checks++;
      if (done_q[0].cyc - drain_cyc !== TMO) begin
        errors++;
        $display("FAIL tmo_latency got %0d want %0d",
                 done_q[0].cyc - drain_cyc, TMO);
      end
    end
    checks++;
    if (res_q.size() !== NRES) begin
      errors++;
      $display("FAIL tmo_count got %0d want %0d", res_q.size(), NRES);
    end
    cycle();
    checks++;
    if (busy !== 1'b0 || gnt !== 2'b00) begin
      errors++;
      $display("FAIL tmo_idle got busy=%b gnt=%b want 0 00", busy, gnt);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    mode = 3;
    run_frames(1, 0, 3000, ok);
    mode = 0;
    checks++;
    if (!ok || done_q.size() == 0 || done_q[0].err !== 1) begin
      errors++;
      $display("FAIL ovf_error got ok=%0d done=%0d want error frame",
               ok, done_q.size());
    end
    checks++;
    if (res_q.size() !== NRES) begin
      errors++;
      $display("FAIL ovf_count got %0d want %0d", res_q.size(), NRES);
    end
  endtask

  task automatic test_short_frame();
    bit ok;
    do_reset();
    mode = 2;
    run_frames(1, 0, 3000, ok);
    mode = 0;
    checks++;
    if (!ok || done_q.size() == 0 || done_q[0].err !== 1) begin
      errors++;
      $display("FAIL short_error got ok=%0d done=%0d want error frame",
               ok, done_q.size());
    end
    checks++;
    if (res_q.size() !== 10) begin
      errors++;
      $display("FAIL short_count got %0d want 10", res_q.size());
    end
    for (int k = 0; k < res_q.size() && k < 10; k++) begin
      checks++;
      if (res_q[k].idx !== k || res_q[k].data !== gold[0][k]) begin
        errors++;
        $display("FAIL short_res[%0d] got idx=%0d d=%0d want %0d %0d",
                 k, res_q[k].idx, res_q[k].data, k, gold[0][k]);
      end
    end
  endtask

  task automatic test_rst_mid_frame();
    bit ok;
    bit started;
    int nd;
    started = 1'b0;
    ok = 1'b0;
    req = 2'b01;
    for (int n = 0; n < 2000; n++) begin
      cycle();
      if (fe_start) begin
        started = 1'b1;
        req = '0;
      end
      if (started && src_pos[0] == 500) begin
        ok = 1'b1;
        break;
      end
    end
    req = '0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rst_reach got no pixel 500 want reached");
    end
    nd = done_q.size();
    rst = 1'b1;
    cycle();
    checks++;
    if (gnt !== 2'b00 || busy !== 1'b0 || frame_done !== 1'b0 ||
        res_valid !== 1'b0 || src_ready !== 2'b00) begin
      errors++;
      $display("FAIL rst_abort got gnt=%b busy=%b fd=%b rv=%b rdy=%b want all 0",
               gnt, busy, frame_done, res_valid, src_ready);
    end
    rst = 1'b0;
    checks++;
    if (done_q.size() !== nd) begin
      errors++;
      $display("FAIL rst_no_done got %0d want %0d", done_q.size(), nd);
    end
    res_q.delete();
    done_q.delete();
    run_frames(1, 0, 3000, ok);
    checks++;
    if (!ok || done_q.size() !== 1 || done_q[0].err !== 0 ||
        res_q.size() !== NRES) begin
      errors++;
      $display("FAIL rst_restart got ok=%0d done=%0d res=%0d want 1 1 225",
               ok, done_q.size(), res_q.size());
    end
    for (int k = 0; k < res_q.size() && k < NRES; k++) begin
      checks++;
      if (res_q[k].idx !== k || res_q[k].data !== gold[0][k]) begin
        errors++;
        $display("FAIL rst_res[%0d] got idx=%0d d=%0d want %0d %0d",
                 k, res_q[k].idx, res_q[k].data, k, gold[0][k]);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < NPIX; i++) ref_img[i] = pix(s, i);
      for (int k = 0; k < NRES; k++) gold[s][k] = feat(ref_img, k);
    end
    test_reset();
    test_src0_xor();
    test_round_robin();
    test_alternate();
    test_gaps();
    test_timeout();
    test_overflow();
    test_short_frame();
    test_rst_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fe_frame_scheduler.md
Name: fe_frame_scheduler

Overview:
Sequences the shared Feature_Extractor (3x3 conv + ReLU + 2x2 max-pool, 32x32 in, 15x15 out) between two frame sources. It grants the extractor to one requester at a time, round-robin, pulses the extractor start, and forwards that source's pixel stream. It collects the 225 pooled results, tagging each with source id and index, and reports frame completion or error. It sits between the camera/frame-buffer readers and the extractor.

Parameters:
IMG_WIDTH, 32, input frame width in pixels
IMG_HEIGHT, 32, input frame height in pixels
RESULT_COUNT, 225, expected pooled outputs per frame ((IMG_WIDTH-2)/2)^2
TIMEOUT_CYCLES, 4096, max cycles in DRAIN waiting for fe_done

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  2  per-source frame request, level, held until gnt
gnt  out  2  one-hot grant, held for the whole frame
src_valid  in  2  per-source pixel valid
src_pixel  in  16  per-source pixel, source i on bits [8i+7:8i]
src_ready  out  2  per-source pixel accept
fe_start  out  1  one-cycle start pulse to extractor
fe_pixel_valid  out  1  pixel valid to extractor
fe_pixel  out  8  pixel to extractor
fe_result  in  22  signed pooled result from extractor
fe_result_valid  in  1  extractor result strobe
fe_done  in  1  extractor frame-complete strobe
res_data  out  22  forwarded result, signed
res_valid  out  1  result strobe
res_id  out  1  source id of res_data
res_index  out  8  result index within frame, 0..RESULT_COUNT-1
frame_done  out  1  one-cycle frame-complete pulse
frame_id  out  1  source id of completed frame, valid with frame_done
frame_error  out  1  valid with frame_done: count mismatch or timeout
busy  out  1  high in every state except IDLE

Behaviour:
- One clock, clk. Reset is synchronous, active-high on rst. All outputs are 0 in reset. The last-served pointer resets to 1, so source 0 wins the first tie. The extractor shares the same rst.
- FSM states: IDLE, START, STREAM, DRAIN, DONE.
- IDLE: if any req bit is set, pick the winner. A lone requester wins. If both request, the source != last-served wins. Register gnt and go to START. The request is sampled in cycle N; gnt and fe_start are high in cycle N+1.
- START: fe_start=1 for exactly this cycle. Clear pix_cnt, res_cnt and the timeout counter, then go to STREAM.
- STREAM: src_ready[g]=1, other ready=0. fe_pixel_valid = src_valid[g] and fe_pixel = src_pixel[g], combinational passthrough with no extractor backpressure. Gaps (valid low) are allowed. pix_cnt counts accepted pixels. After pixel IMG_WIDTH*IMG_HEIGHT-1 (1023) is accepted, go to DRAIN; src_ready drops the next cycle.
- DRAIN: the timeout counter increments each cycle. On fe_done, or when the counter reaches TIMEOUT_CYCLES-1, go to DONE.
- DONE: for one cycle, frame_done=1, frame_id=g, frame_error=(res_cnt!=RESULT_COUNT) or timeout. Update last-served to g, clear gnt, go to IDLE. A new grant may issue in the cycle after DONE.
- Result forwarding applies in STREAM, DRAIN and DONE; fe_result_valid may assert while pixels still stream.
  - Registered, 1-cycle latency: res_valid, res_data=fe_result, res_id=g, res_index=res_cnt.
  - res_cnt saturates at RESULT_COUNT. Results beyond that are dropped (no res_valid) and set the error.
  - fe_result_valid in IDLE or START is ignored.
- Simultaneous fe_result_valid and fe_done: the result is forwarded, and its res_valid coincides with frame_done.
- fe_done seen in STREAM: latch an error flag, keep streaming, and report frame_error in DONE.
- A req drop mid-frame is ignored; the frame completes. A req bit asserted during a frame waits for IDLE.
- rst mid-frame: return to IDLE on the next edge, all outputs cleared, no frame_done emitted.

Test Plan:
- Src0 only, XOR image 100+(x^y), no gaps: gnt=01 and fe_start one cycle after req. 1024 pixels forwarded, 225 res_valid with res_id=0 and res_index 0..224 matching the golden conv/ReLU/pool values. Then frame_done=1, frame_error=0.
- req=11 from reset: src0 is served first, then src1 (gnt=10). Two frame_done pulses with frame_id 0 then 1, no overlap of gnt.
- Src0 re-requests immediately while src1 is pending: service alternates 0,1,0. No source is granted twice in a row while the other waits.
- Pseudo-random src_valid gaps (~30% idle): same 225 results as the gapless run. fe_pixel_valid is never high when src_valid[g] is low. Exactly 1024 pixels are accepted.
- Extractor model never asserts fe_done: frame_done with frame_error=1 exactly TIMEOUT_CYCLES (4096) cycles after DRAIN entry, then IDLE with busy=0.
- Extractor model gives 10 results then fe_done: frame_error=1, res_index 0..9 only. rst pulsed at pixel 500 of the next frame: the next cycle has gnt=0, busy=0, no frame_done, and a fresh req restarts cleanly.
